// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared state encoding and timing defaults for the ADC channel scheduler
package adc_sched_pkg;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE    = 3'd0;
  localparam sched_state_t ST_PWRUP   = 3'd1;
  localparam sched_state_t ST_SELECT  = 3'd2;
  localparam sched_state_t ST_START   = 3'd3;
  localparam sched_state_t ST_CONVERT = 3'd4;
  localparam sched_state_t ST_WRITE   = 3'd5;
  localparam sched_state_t ST_NEXT    = 3'd6;
  localparam sched_state_t ST_DONE    = 3'd7;

  localparam int DEF_SETTLE_CYC  = 8;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Settle and timeout loads both fit 1..255, so one 8-bit down-counter serves both.
  localparam int TMR_W = 8;

endpackage

// File: rtl/sched_prio_next.sv
// rtl/sched_prio_next.sv - finds the lowest set mask bit at or above a start index
module sched_prio_next #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W:0]     start,
  output logic [CH_W-1:0]   next_idx,
  output logic              next_valid
);

  // Scan downward so the last qualifying hit is the lowest index; start is one bit wider to express "past the end"
  always_comb begin
    next_idx   = '0;
    next_valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((CH_W + 1)'(i) >= start)) begin
        next_idx   = CH_W'(i);
        next_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_channel_scheduler.sv
// rtl/adc_channel_scheduler.sv - multi-channel ADC round sequencer with overflow and timeout accounting
module adc_channel_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int DATA_W      = 12,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rtc_trig,
  input  logic [NUM_CH-1:0]      ch_mask,
  output logic                   adc_enable,
  input  logic                   adc_ready,
  output logic [CH_W-1:0]        adc_ch_sel,
  output logic                   adc_start,
  input  logic                   adc_done,
  input  logic [DATA_W-1:0]      adc_data,
  input  logic                   fifo_full,
  output logic                   fifo_write_en,
  output logic [CH_W+DATA_W-1:0] fifo_wdata,
  output logic                   busy,
  output logic                   round_done,
  output logic                   missed_trig,
  output logic [CNT_W-1:0]       ovf_count,
  output logic                   timeout_err
);

  localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  sched_state_t        state;
  logic [NUM_CH-1:0]   mask_q;
  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     ch_sel_q;
  logic [DATA_W-1:0]   data_q;
  logic [TMR_W-1:0]    tmr;
  logic [CNT_W-1:0]    ovf_q;
  logic                tout_q;

  logic [NUM_CH-1:0]   find_mask;
  logic [CH_W:0]       find_start;
  logic [CH_W-1:0]     find_idx;
  logic                find_valid;

  // In IDLE the finder picks the first channel of the live mask; elsewhere it walks the latched mask past the pointer
  always_comb begin
    find_mask  = mask_q;
    find_start = {1'b0, ptr} + (CH_W + 1)'(1);
    if (state == ST_IDLE) begin
      find_mask  = ch_mask;
      find_start = '0;
    end
  end

  sched_prio_next #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_prio_next (
    .mask       (find_mask),
    .start      (find_start),
    .next_idx   (find_idx),
    .next_valid (find_valid)
  );

  // Round sequencer; tmr counts settle cycles in SELECT and the ready/done watchdog in PWRUP and CONVERT
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      mask_q   <= '0;
      ptr      <= '0;
      ch_sel_q <= '0;
      data_q   <= '0;
      tmr      <= '0;
      ovf_q    <= '0;
      tout_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rtc_trig) begin
            if (find_valid) begin
              mask_q <= ch_mask;
              ptr    <= find_idx;
              tmr    <= TIMEOUT_LOAD;
              state  <= ST_PWRUP;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_PWRUP: begin
          if (adc_ready) begin
            ch_sel_q <= ptr;
            tmr      <= SETTLE_LOAD;
            state    <= ST_SELECT;
          end else if (tmr == '0) begin
            tout_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_SELECT: begin
          if (tmr == '0) begin
            state <= ST_START;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_START: begin
          tmr   <= TIMEOUT_LOAD;
          state <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (adc_done) begin
            data_q <= adc_data;
            state  <= ST_WRITE;
          end else if (tmr == '0) begin
            tout_q <= 1'b1;
            state  <= ST_NEXT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_WRITE: begin
          if (fifo_full && (ovf_q != '1)) begin
            ovf_q <= ovf_q + CNT_W'(1);
          end
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (find_valid) begin
            ptr      <= find_idx;
            ch_sel_q <= find_idx;
            tmr      <= SETTLE_LOAD;
            state    <= ST_SELECT;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign adc_enable    = (state == ST_PWRUP) || (state == ST_SELECT) || (state == ST_START) ||
                         (state == ST_CONVERT) || (state == ST_WRITE) || (state == ST_NEXT);
  assign adc_ch_sel    = ch_sel_q;
  assign adc_start     = (state == ST_START);
  assign fifo_write_en = (state == ST_WRITE) && !fifo_full;
  assign fifo_wdata    = {ptr, data_q};
  assign busy          = (state != ST_IDLE);
  assign round_done    = (state == ST_DONE);
  assign missed_trig   = rtc_trig && (state != ST_IDLE);
  assign ovf_count     = ovf_q;
  assign timeout_err   = tout_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// tb/tb_adc_channel_scheduler.sv - self-checking bench for adc_channel_scheduler
module tb_adc_channel_scheduler;

  localparam int NCH    = 4;
  localparam int SETTLE = 8;
  localparam int TOUT   = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        rtc_trig;
  logic [3:0]  ch_mask;
  logic        adc_enable;
  logic        adc_ready;
  logic [1:0]  adc_ch_sel;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [13:0] fifo_wdata;
  logic        busy;
  logic        round_done;
  logic        missed_trig;
  logic [7:0]  ovf_count;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  int          gcyc = 0;
  int          rn   = 0;
  int          rdel = 1000;
  int          conv [NCH];
  logic [11:0] dat  [NCH];
  logic        armed   = 1'b0;
  int          ccnt    = 0;
  logic [1:0]  cch     = 2'd0;
  logic        spur_en = 1'b0;

  logic [13:0] wr_q [$];
  int          done_cyc;
  int          done_cnt;
  int          first_wr;
  int          missed_cnt;
  logic        en_seen;
  logic        en_at_done;
  logic [1:0]  prev_sel  = 2'd0;
  int          sel_chg   = 0;
  logic        sel_fresh = 1'b0;

  int          exp_ovf  = 0;
  logic        exp_tout = 1'b0;

  always #5 clk = ~clk;

  adc_channel_scheduler #(
    .NUM_CH      (4),
    .CH_W        (2),
    .DATA_W      (12),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TOUT),
    .CNT_W       (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rtc_trig      (rtc_trig),
    .ch_mask       (ch_mask),
    .adc_enable    (adc_enable),
    .adc_ready     (adc_ready),
    .adc_ch_sel    (adc_ch_sel),
    .adc_start     (adc_start),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_wdata    (fifo_wdata),
    .busy          (busy),
    .round_done    (round_done),
    .missed_trig   (missed_trig),
    .ovf_count     (ovf_count),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input int obs, input int want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic clear_rec();
    wr_q.delete();
    done_cyc   = -1;
    done_cnt   = 0;
    first_wr   = -1;
    missed_cnt = 0;
    en_seen    = 1'b0;
    en_at_done = 1'b0;
  endtask

  // One clock: drive trigger/mask and the ADC behaviour, then observe the DUT away from the edge.
  task automatic tick(input logic trig, input logic [3:0] cm);
    @(negedge clk);
    gcyc++;
    rtc_trig  = trig;
    ch_mask   = cm;
    adc_ready = adc_enable && (rn >= rdel);
    adc_done  = 1'b0;
    adc_data  = 12'($urandom);
    if (armed) begin
      ccnt++;
      if (ccnt == conv[cch]) begin
        adc_done = 1'b1;
        adc_data = dat[cch];
        armed    = 1'b0;
      end
    end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
      adc_done = 1'b1;
    end
    if (adc_start) begin
      armed = 1'b1;
      ccnt  = 0;
      cch   = adc_ch_sel;
    end
    #1;
    if (fifo_write_en) begin
      wr_q.push_back(fifo_wdata);
      if (first_wr < 0) first_wr = rn;
    end
    if (round_done) begin
      done_cnt++;
      done_cyc   = rn;
      en_at_done = adc_enable;
    end
    if (adc_enable) en_seen = 1'b1;
    if (missed_trig) missed_cnt++;
    if (adc_ch_sel != prev_sel) begin
      prev_sel  = adc_ch_sel;
      sel_chg   = gcyc;
      sel_fresh = 1'b1;
    end
    if (adc_start) begin
      if (sel_fresh) chk("settle_to_start", gcyc - sel_chg, SETTLE);
      sel_fresh = 1'b0;
    end
    rn++;
  endtask

  // Runs one round and compares it against a cycle-arithmetic reference of the round.
  task automatic run_round(input logic [3:0] mask, input int rd, input logic full, input int mid);
    int          t;
    int          len;
    int          exp_first;
    logic [13:0] exp_q [$];
    exp_first = -1;
    if (mask == 4'd0) begin
      len = 1;
    end else if (rd > TOUT) begin
      len      = 1 + TOUT;
      exp_tout = 1'b1;
    end else begin
      t = 1 + rd;
      for (int ch = 0; ch < NCH; ch++) begin
        if (mask[ch]) begin
          if (conv[ch] > TOUT) begin
            t += SETTLE + 1 + TOUT + 1;
            exp_tout = 1'b1;
          end else begin
            if (full) begin
              if (exp_ovf < 255) exp_ovf++;
            end else begin
              exp_q.push_back({2'(ch), dat[ch]});
              if (exp_first < 0) exp_first = t + SETTLE + 1 + conv[ch];
            end
            t += SETTLE + 1 + conv[ch] + 2;
          end
        end
      end
      len = t;
    end

    rdel      = rd;
    fifo_full = full;
    rn        = 0;
    clear_rec();
    chk("idle_before_trig", busy, 0);
    tick(1'b1, mask);
    while (done_cnt == 0 && rn < 4000) tick(rn == mid, 4'($urandom));
    tick(1'b0, 4'($urandom));
    chk("idle_after_round", busy, 0);
    chk("done_cycle", done_cyc, len);
    chk("done_pulses", done_cnt, 1);
    chk("enable_at_done", en_at_done, 0);
    chk("enable_seen", en_seen, (mask != 4'd0) ? 1 : 0);
    chk("write_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) chk("write_word", wr_q[i], exp_q[i]);
    if (exp_q.size() > 0) chk("first_write_cycle", first_wr, exp_first);
    chk("ovf_count", ovf_count, exp_ovf);
    chk("timeout_err", timeout_err, exp_tout);
    chk("missed_trig", missed_cnt, (mid >= 1 && mid <= len) ? 1 : 0);
    rdel = 1000;
  endtask

  task automatic set_conv_all(input int c);
    for (int i = 0; i < NCH; i++) conv[i] = c;
  endtask

  initial begin
    rst = 1'b0; rtc_trig = 1'b0; ch_mask = 4'd0; adc_ready = 1'b0;
    adc_done = 1'b0; adc_data = 12'd0; fifo_full = 1'b0;
    for (int i = 0; i < NCH; i++) dat[i] = 12'h100 + 12'(i);
    set_conv_all(5);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_enable", adc_enable, 0);
    chk("rst_start", adc_start, 0);
    chk("rst_ch_sel", adc_ch_sel, 0);
    chk("rst_write_en", fifo_write_en, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_round_done", round_done, 0);
    chk("rst_missed", missed_trig, 0);
    chk("rst_ovf", ovf_count, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // full round, ready on 3rd cycle, 5-cycle conversions
    run_round(4'b1011, 3, 1'b0, -1);
    // FIFO full for the whole round
    set_conv_all(3);
    run_round(4'b0011, 2, 1'b1, -1);
    // empty mask
    run_round(4'b0000, 1, 1'b0, -1);
    // trigger while busy, inside the first conversion
    set_conv_all(4);
    run_round(4'b1011, 2, 1'b0, 1 + 2 + SETTLE + 1 + 1);
    // conversion withheld on channel 1
    set_conv_all(3);
    conv[1] = 1000;
    run_round(4'b0111, 1, 1'b0, -1);
    // ready withheld
    set_conv_all(3);
    run_round(4'b0101, 1000, 1'b0, -1);

    // randomized rounds with spurious adc_done outside conversions
    spur_en = 1'b1;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NCH; i++) begin
        conv[i] = $urandom_range(1, 8);
        dat[i]  = 12'($urandom);
      end
      run_round(4'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 60));
    end

    // overflow saturation
    set_conv_all(1);
    while (exp_ovf < 255) run_round(4'b1111, 1, 1'b1, -1);
    run_round(4'b1111, 1, 1'b1, -1);
    run_round(4'b0011, 1, 1'b1, -1);
    spur_en = 1'b0;

    // reset during SELECT of channel 2
    set_conv_all(2);
    clear_rec();
    rdel = 1;
    fifo_full = 1'b0;
    rn = 0;
    tick(1'b1, 4'b0111);
    while ((adc_ch_sel != 2'd2 || rn < 3) && rn < 400) tick(1'b0, 4'b0111);
    chk("reached_select_ch2", adc_ch_sel, 2);
    @(negedge clk);
    rst = 1'b0; rtc_trig = 1'b0; adc_ready = 1'b0; adc_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_enable", adc_enable, 0);
    chk("mid_rst_start", adc_start, 0);
    chk("mid_rst_ch_sel", adc_ch_sel, 0);
    chk("mid_rst_write_en", fifo_write_en, 0);
    chk("mid_rst_wdata", fifo_wdata, 0);
    chk("mid_rst_round_done", round_done, 0);
    chk("mid_rst_missed", missed_trig, 0);
    chk("mid_rst_ovf", ovf_count, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    exp_ovf   = 0;
    exp_tout  = 1'b0;
    armed     = 1'b0;
    prev_sel  = 2'd0;
    sel_fresh = 1'b0;
    rdel      = 1000;

    // clean round after reset
    for (int i = 0; i < NCH; i++) dat[i] = 12'($urandom);
    run_round(4'b0111, 2, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
